// File: rtl/pc_sequencer.sv
// Next-PC controller: chooses the fetch address each cycle, drives the PC register
// enable, raises pipeline flushes, runs the halt/resume FSM and keeps perf counters.
module pc_sequencer #(
    parameter int                  AddrBits    = 32,
    parameter logic [AddrBits-1:0] ResetVector = '0,
    parameter int                  CntBits     = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [AddrBits-1:0] pc_q,
    input  logic                stall,
    input  logic                bp_hit,
    input  logic [AddrBits-1:0] bp_target,
    input  logic                ex_redirect,
    input  logic [AddrBits-1:0] ex_target,
    input  logic                halt_req,
    input  logic                go,
    output logic [AddrBits-1:0] pc_d,
    output logic                pc_we,
    output logic                flush_ifid,
    output logic                flush_idex,
    output logic                halted,
    output logic [CntBits-1:0]  cyc_cnt,
    output logic [CntBits-1:0]  redir_cnt,
    output logic [CntBits-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state, state_next;
    logic   cyc_inc, redir_inc, stall_inc;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CntBits-1:0] sat_inc(input logic [CntBits-1:0] v);
        return (&v) ? v : v + CntBits'(1);
    endfunction

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= BOOT;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        pc_d       = pc_q;
        pc_we      = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        halted     = 1'b0;
        cyc_inc    = 1'b0;
        redir_inc  = 1'b0;
        stall_inc  = 1'b0;

        unique case (state)
            BOOT: begin
                pc_d       = ResetVector;
                pc_we      = 1'b1;
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                cyc_inc = 1'b1;
                // The redirecting instruction sits in EX, so it overrides stall and halt.
                if (ex_redirect) begin
                    pc_d       = ex_target;
                    pc_we      = 1'b1;
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    redir_inc  = 1'b1;
                end else if (halt_req) begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    state_next = HALTED;
                end else if (stall) begin
                    stall_inc = 1'b1;
                end else if (bp_hit) begin
                    pc_d  = bp_target;
                    pc_we = 1'b1;
                end else begin
                    pc_d  = pc_q + AddrBits'(4);
                    pc_we = 1'b1;
                end
            end
            HALTED: begin
                halted = 1'b1;
                if (go) state_next = RUN;
            end
            default: state_next = BOOT;
        endcase

        // Reset acts on the outputs immediately, without waiting for a clock.
        if (Reset) begin
            pc_d       = ResetVector;
            pc_we      = 1'b0;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            halted     = 1'b0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cyc_cnt   <= '0;
            redir_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (cyc_inc)   cyc_cnt   <= sat_inc(cyc_cnt);
            if (redir_inc) redir_cnt <= sat_inc(redir_cnt);
            if (stall_inc) stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule
